// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the serial adder.
package serial_adder_pkg;

  // Control FSM states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Chunk counter width: enough bits to index N chunks, never narrower than 1
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder; chained CHUNK-deep to form the per-cycle adder slice.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  // Sum and majority carry
  always_comb begin
    s  = a ^ b ^ ci;
    co = (a & b) | (a & ci) | (b & ci);
  end

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per cycle, LSB first,
// through a ripple chain of fa_cell instances and a carry register.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  // Reject illegal parameter combinations at elaboration
  if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
    $error("serial_adder: WIDTH must be in 2..64");
  end
  if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("serial_adder: WIDTH must be an integer multiple of CHUNK");
  end

  state_e state_q, state_d;

  // Operands shift right one chunk per RUN cycle so the active chunk is
  // always in the low bits; b is stored pre-inverted for subtraction.
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  // Partial result fills from the top, so after N chunks it is aligned
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  // Ripple chain for the current chunk
  logic [CHUNK:0]         c;
  logic [CHUNK-1:0]       s_chunk;
  logic [WIDTH+CHUNK-1:0] res_ext;
  logic                   last_chunk;

  assign c[0] = carry_q;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    fa_cell u_fa (
      .a  (a_q[i]),
      .b  (b_q[i]),
      .ci (c[i]),
      .s  (s_chunk[i]),
      .co (c[i+1])
    );
  end

  assign res_ext    = {s_chunk, res_q};
  assign last_chunk = (cnt_q == LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; start only matters in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last_chunk) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_q != S_IDLE);
    done = (state_q == S_DONE);
  end

  // Datapath next-state: capture in IDLE, step one chunk per RUN cycle,
  // publish the result on the final chunk (the edge that enters DONE)
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? ~cin : cin;
          cnt_d   = '0;
          res_d   = '0;
        end
      end
      S_RUN: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        res_d   = res_ext[WIDTH+CHUNK-1:CHUNK];
        carry_d = c[CHUNK];
        cnt_d   = cnt_q + CW'(1);
        if (last_chunk) begin
          sum_d  = res_ext[WIDTH+CHUNK-1:CHUNK];
          cout_d = c[CHUNK];
          // carry into MSB vs carry out of MSB
          ovf_d  = c[CHUNK-1] ^ c[CHUNK];
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed, table-driven bench for serial_adder (8-bit, CHUNK=1 and CHUNK=4).
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  // CHUNK=1 instance
  logic       start, sub, cin;
  logic [7:0] a, b;
  logic       busy, done, cout, ovf;
  logic [7:0] sum;
  // CHUNK=4 instance
  logic       start4, sub4, cin4;
  logic [7:0] a4, b4;
  logic       busy4, done4, cout4, ovf4;
  logic [7:0] sum4;

  int n_tests = 0;
  int n_fail  = 0;
  logic [9:0] exp_prev;  // {sum, cout, ovf} expected to be held through RUN

  typedef struct {
    logic       s;
    logic [7:0] av;
    logic [7:0] bv;
    logic       c;
    logic [7:0] es;
    logic       ec;
    logic       eo;
  } vec_t;

  vec_t tbl[10];

  serial_adder #(.WIDTH(8), .CHUNK(1)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  serial_adder #(.WIDTH(8), .CHUNK(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .sub(sub4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One operation on the CHUNK=1 instance; inputs are scrambled after capture
  task automatic run_op(input vec_t v, input string tag);
    int   lat, bcnt;
    bit   seen, hold_ok;
    @(negedge clk);
    check({tag, "_idle"}, {62'd0, busy, done}, 64'd0);
    start = 1'b1; sub = v.s; a = v.av; b = v.bv; cin = v.c;
    @(posedge clk);  // edge k
    @(negedge clk);
    start = 1'b0; sub = ~v.s; a = ~v.av; b = v.av ^ 8'h5a; cin = ~v.c;
    lat = 1; bcnt = 0; seen = 0; hold_ok = 1;
    while (!seen && lat <= 40) begin
      if (busy) bcnt++;
      if (done) seen = 1;
      else begin
        if ({sum, cout, ovf} !== exp_prev) hold_ok = 0;
        @(negedge clk);
        lat++;
      end
    end
    check({tag, "_latency"}, 64'(lat), 64'd9);
    check({tag, "_busy_cycles"}, 64'(bcnt), 64'd9);
    check({tag, "_hold"}, {63'd0, hold_ok}, 64'd1);
    check({tag, "_sum"}, {56'd0, sum}, {56'd0, v.es});
    check({tag, "_cout_ovf"}, {62'd0, cout, ovf}, {62'd0, v.ec, v.eo});
    exp_prev = {v.es, v.ec, v.eo};
  endtask

  // One operation on the CHUNK=4 instance
  task automatic run4(input vec_t v, input string tag);
    int lat;
    @(negedge clk);
    start4 = 1'b1; sub4 = v.s; a4 = v.av; b4 = v.bv; cin4 = v.c;
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0; a4 = 8'h00; b4 = 8'hff;
    lat = 1;
    while (!done4 && lat <= 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'd3);
    check({tag, "_sum"}, {56'd0, sum4}, {56'd0, v.es});
    check({tag, "_cout_ovf"}, {62'd0, cout4, ovf4}, {62'd0, v.ec, v.eo});
  endtask

  initial begin
    int   dcnt, bcnt;
    logic [7:0] got_sum;
    vec_t v;

    //           sub  a      b      cin  sum    cout  ovf
    tbl[0] = '{1'b0, 8'hff, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 8'h7f, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 8'h05, 8'h07, 1'b0, 8'hfe, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 8'h80, 8'h01, 1'b0, 8'h7f, 1'b1, 1'b1};
    tbl[4] = '{1'b0, 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 8'h10, 8'h01, 1'b1, 8'h0e, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    tbl[7] = '{1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 8'hff, 8'hff, 1'b1, 8'hff, 1'b1, 1'b0};
    tbl[9] = '{1'b1, 8'h7f, 8'hff, 1'b0, 8'h80, 1'b0, 1'b1};

    rst = 1'b1; start = 0; sub = 0; a = 0; b = 0; cin = 0;
    start4 = 0; sub4 = 0; a4 = 0; b4 = 0; cin4 = 0;
    exp_prev = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {53'd0, busy, done, sum, cout, ovf}, 64'd0);
    check("reset_outputs4", {53'd0, busy4, done4, sum4, cout4, ovf4}, 64'd0);
    rst = 1'b0;

    // Table: issued back to back, each start in the first IDLE cycle
    for (int i = 0; i < 10; i++) run_op(tbl[i], $sformatf("vec%0d", i));

    // CHUNK=4: 3C + 0F + 1 = 4C, and a signed overflow case
    v = '{1'b0, 8'h3c, 8'h0f, 1'b1, 8'h4c, 1'b0, 1'b0};
    run4(v, "c4_add");
    v = '{1'b0, 8'h7f, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    run4(v, "c4_ovf");

    // Extra start during RUN (different operands) and during DONE are ignored
    @(negedge clk);
    start = 1'b1; sub = 1'b0; a = 8'h11; b = 8'h22; cin = 1'b0;
    @(posedge clk);
    dcnt = 0; bcnt = 0; got_sum = 8'hxx;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (done) begin dcnt++; got_sum = sum; end
      start = (j == 2) || done;
      if (j == 2) begin sub = 1'b1; a = 8'hff; b = 8'hff; cin = 1'b1; end
    end
    start = 1'b0;
    check("busy_start_done_count", 64'(dcnt), 64'd1);
    check("busy_start_sum", {56'd0, got_sum}, 64'h33);
    check("busy_start_busy_cycles", 64'(bcnt), 64'd9);
    exp_prev = {8'h33, 1'b0, 1'b0};

    // Reset in RUN cycle 3 aborts: outputs clear, no done, then normal op
    @(negedge clk);
    start = 1'b1; sub = 1'b0; a = 8'h01; b = 8'h02; cin = 1'b0;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_outputs", {53'd0, busy, done, sum, cout, ovf}, 64'd0);
    rst = 1'b0;
    dcnt = 0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    check("abort_no_done", 64'(dcnt), 64'd0);
    exp_prev = '0;
    v = '{1'b0, 8'h21, 8'h13, 1'b0, 8'h34, 1'b0, 1'b0};
    run_op(v, "after_abort");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global bound so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
